multicycle_controller: RTL

- Parametrised successor to the single-cycle CONTROLLER decoder: a multi-cycle RV32I main control FSM.
- Sequences fetch, decode, execute, memory and writeback, and drives the datapath enables and alu_op.
- Handshakes with a wait-state memory port and an optional multi-cycle MUL/DIV unit.
- Traps on illegal encodings and on memory timeout.

---
 rtl/multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main control FSM: fetch/decode/exec/mem/writeback sequencing,
// wait-state memory handshake with optional timeout, and optional MUL/DIV hand-off.
module multicycle_controller #(
  parameter int ENABLE_M_EXT  = 0,
  parameter int MEM_TIMEOUT   = 16,
  parameter int TIMEOUT_WIDTH = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       branch_cond,
  input  logic       mem_ready,
  input  logic       muldiv_done,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       muldiv_start,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       bus_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_MULDIV = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_BRANCH = 3'd4,
    C_JUMP   = 3'd5,
    C_UPPER  = 3'd6
  } class_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam bit                     TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_MAX = TIMEOUT_WIDTH'(MEM_TIMEOUT);

  // Returns {illegal, class} for the instruction currently held in IR.
  function automatic logic [3:0] classify(input logic [6:0] op, input logic [2:0] f3,
                                          input logic [6:0] f7);
    logic [3:0] res;
    res = {1'b1, C_ALU};
    case (op)
      OPC_OP: begin
        if (f7 == F7_BASE) begin
          res = {1'b0, C_ALU};
        end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
          res = {1'b0, C_ALU};
        end else if (f7 == F7_MUL && ENABLE_M_EXT != 0) begin
          res = {1'b0, C_MULDIV};
        end else begin
          res = {1'b1, C_ALU};
        end
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001) begin
          res = {(f7 != F7_BASE), C_ALU};
        end else if (f3 == 3'b101) begin
          res = {!(f7 == F7_BASE || f7 == F7_ALT), C_ALU};
        end else begin
          res = {1'b0, C_ALU};
        end
      end
      OPC_LOAD:   res = {1'b0, C_LOAD};
      OPC_STORE:  res = {1'b0, C_STORE};
      OPC_BRANCH: res = {1'b0, C_BRANCH};
      OPC_JAL:    res = {1'b0, C_JUMP};
      OPC_JALR:   res = {1'b0, C_JUMP};
      OPC_LUI:    res = {1'b0, C_UPPER};
      OPC_AUIPC:  res = {1'b0, C_UPPER};
      default:    res = {1'b1, C_ALU};
    endcase
    return res;
  endfunction

  state_t                   r_state;
  class_t                   r_class;
  logic [TIMEOUT_WIDTH-1:0] r_wait_cnt;
  logic                     r_md_started;
  logic                     r_illegal;
  logic                     r_bus_error;

  state_t     w_next_state;
  logic [3:0] w_decoded;
  class_t     w_dec_class;
  logic       w_mem_phase;
  logic       w_timeout;
  logic       w_set_illegal;
  logic       w_set_bus_error;

  assign w_decoded   = classify(opcode, funct3, funct7);
  assign w_dec_class = class_t'(w_decoded[2:0]);
  assign w_mem_phase = (r_state == S_FETCH) || (r_state == S_MEM);
  // Ready in the same cycle the limit is reached still wins over the timeout.
  assign w_timeout   = TIMEOUT_EN && w_mem_phase && !mem_ready && (r_wait_cnt == TIMEOUT_MAX);

  assign state     = r_state;
  assign illegal   = r_illegal;
  assign bus_error = r_bus_error;

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state    = r_state;
    w_set_illegal   = 1'b0;
    w_set_bus_error = 1'b0;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    ir_we           = 1'b0;
    pc_we           = 1'b0;
    pc_src          = 2'b00;
    alu_op          = 2'b00;
    muldiv_start    = 1'b0;
    reg_we          = 1'b0;
    wb_sel          = 2'b00;
    case (r_state)
      S_RESET: w_next_state = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we        = 1'b1;
          pc_we        = 1'b1;
          w_next_state = S_DECODE;
        end else if (w_timeout) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_TRAP;
        end else begin
          w_next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (w_decoded[3]) begin
          w_set_illegal = 1'b1;
          w_next_state  = S_TRAP;
        end else begin
          w_next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_class)
          C_ALU: begin
            alu_op       = 2'b10;
            w_next_state = S_WB;
          end
          C_MULDIV: begin
            alu_op       = 2'b11;
            muldiv_start = !r_md_started;
            if (muldiv_done) begin
              w_next_state = S_WB;
            end else begin
              w_next_state = S_EXEC;
            end
          end
          C_LOAD, C_STORE: w_next_state = S_MEM;
          C_BRANCH: begin
            alu_op = 2'b01;
            if (branch_cond) begin
              pc_we  = 1'b1;
              pc_src = 2'b01;
            end else begin
              pc_we  = 1'b0;
              pc_src = 2'b00;
            end
            w_next_state = S_FETCH;
          end
          C_JUMP: begin
            pc_we        = 1'b1;
            pc_src       = 2'b10;
            w_next_state = S_WB;
          end
          C_UPPER: w_next_state = S_WB;
          default: w_next_state = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (r_class == C_STORE);
        if (mem_ready) begin
          if (r_class == C_LOAD) begin
            w_next_state = S_WB;
          end else begin
            w_next_state = S_FETCH;
          end
        end else if (w_timeout) begin
          w_set_bus_error = 1'b1;
          w_next_state    = S_TRAP;
        end else begin
          w_next_state = S_MEM;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        case (r_class)
          C_LOAD:  wb_sel = 2'b01;
          C_JUMP:  wb_sel = 2'b10;
          default: wb_sel = 2'b00;
        endcase
        w_next_state = S_FETCH;
      end
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_TRAP;
    endcase
  end

  // State, latched instruction class, wait counter and sticky fault flags.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_RESET;
      r_class      <= C_ALU;
      r_wait_cnt   <= '0;
      r_md_started <= 1'b0;
      r_illegal    <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE && !w_decoded[3]) begin
        r_class <= w_dec_class;
      end
      if (w_next_state != r_state) begin
        r_wait_cnt   <= '0;
        r_md_started <= 1'b0;
      end else begin
        if (w_mem_phase && !mem_ready && r_wait_cnt != '1) begin
          r_wait_cnt <= r_wait_cnt + TIMEOUT_WIDTH'(1);
        end
        if (r_state == S_EXEC) begin
          r_md_started <= 1'b1;
        end
      end
      r_illegal   <= r_illegal | w_set_illegal;
      r_bus_error <= r_bus_error | w_set_bus_error;
    end
  end

endmodule
